// File: rtl/fetch_stage.sv
// Instruction fetch stage: IDLE/REQ/BLOCK fetch FSM feeding a one-entry IF/ID output slot
// backed by a one-entry skid register. branch_taken flushes and redirects in any state.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_count output (accepted instructions).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode_out,
  output logic [31:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StBlock} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;

  logic [31:0] redirect_pc;
  logic        accept;

  assign redirect_pc = branch_target & 32'hFFFF_FFFC;
  assign accept      = valid_q & ~stall;

  // A branch kills the request in the same cycle, so any ack alongside it is never seen.
  assign imem_req   = req_q & ~branch_taken;
  assign imem_addr  = pc_q & 32'hFFFF_FFFC;
  assign valid_out  = valid_q;
  assign instr_out  = instr_q;
  assign opcode_out = instr_q[31:26];
  assign pc_out     = pc_out_q;

  // Fetch FSM with registered request, PC, output slot and skid register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (branch_taken) begin
      state_q      <= StReq;
      pc_q         <= redirect_pc;
      req_q        <= 1'b1;
      valid_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StReq;
          req_q   <= 1'b1;
        end
        StReq: begin
          if (imem_ack) begin
            pc_q <= pc_q + 32'd4;
            if (!valid_q || !stall) begin
              // Slot empty or draining this edge: fill it directly.
              instr_q  <= imem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
            end else begin
              // Slot held by a stalled decode: park the word and stop requesting.
              skid_instr_q <= imem_rdata;
              skid_pc_q    <= pc_q;
              state_q      <= StBlock;
              req_q        <= 1'b0;
            end
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end
        StBlock: begin
          if (!stall) begin
            instr_q      <= skid_instr_q;
            pc_out_q     <= skid_pc_q;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            state_q      <= StReq;
            req_q        <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;

  // Count every instruction decode takes from the output slot; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a queue-based reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [5:0]  opcode_out;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending instructions in program order (head = output slot).
  bit          m_idle;
  logic [31:0] m_pc;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_count;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .valid_out     (valid_out),
    .instr_out     (instr_out),
    .opcode_out    (opcode_out),
    .pc_out        (pc_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit exp_req();
    return !reset && !m_idle && (q_instr.size() < 2) && !branch_taken;
  endfunction

  task automatic model_reset();
    m_idle  = 1'b1;
    m_pc    = 32'h0000_0000;
    m_count = 32'd0;
    q_instr.delete();
    q_pc.delete();
  endtask

  task automatic check_outputs();
    bit       r;
    bit [1:0] lo;
    r  = exp_req();
    lo = imem_addr[1:0];
    check_val("imem_req", {31'd0, imem_req}, {31'd0, r});
    check_val("addr_align", {30'd0, lo}, 32'd0);
    if (r) check_val("imem_addr", imem_addr, m_pc);
    check_val("valid_out", {31'd0, valid_out}, {31'd0, q_instr.size() > 0});
    if (q_instr.size() > 0) begin
      check_val("instr_out", instr_out, q_instr[0]);
      check_val("pc_out", pc_out, q_pc[0]);
      check_val("opcode_out", {26'd0, opcode_out}, {26'd0, q_instr[0][31:26]});
    end
`ifdef FETCH_PERF_CNT_EN
    check_val("fetch_count", fetch_count, m_count);
`endif
  endtask

  // Advance the model across the coming rising edge using the inputs now applied.
  task automatic model_step();
    bit acc;
    bit ack_ok;
    acc    = (q_instr.size() > 0) && !stall;
    ack_ok = exp_req() && imem_ack;
    if (acc) m_count = m_count + 32'd1;
    if (branch_taken) begin
      q_instr.delete();
      q_pc.delete();
      m_pc   = branch_target & 32'hFFFF_FFFC;
      m_idle = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      if (acc) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (ack_ok) begin
        q_instr.push_back(mem_word(m_pc));
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input bit st, input bit ack, input bit br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    stall         = st;
    imem_ack      = ack;
    branch_taken  = br;
    branch_target = tgt;
    @(negedge clk);
    check_outputs();
    model_step();
  endtask

  task automatic rand_cycle();
    cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 15) == 0), $urandom);
  endtask

  initial begin
    reset         = 1'b1;
    imem_ack      = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    model_reset();
    #2;
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_valid", {31'd0, valid_out}, 32'd0);
    check_val("rst_instr", instr_out, 32'd0);
    check_val("rst_pc_out", pc_out, 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);

    // Release between edges; IDLE cycle follows.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
    model_step();

    // Streaming: ack every cycle, no stall.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    // Stall for 3 cycles with acks arriving, then release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    // Branch alongside an ack: data discarded, redirect to aligned target.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    // Delayed ack.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    // Branch near the top of memory to exercise PC wrap.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF6);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0);

    for (int i = 0; i < 2000; i++) rand_cycle();

    // Asynchronous reset in the middle of an outstanding request.
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_val("async_req", {31'd0, imem_req}, 32'd0);
    check_val("async_valid", {31'd0, valid_out}, 32'd0);
    check_val("async_pc_out", pc_out, 32'd0);
    model_reset();
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    check_val("async_hold_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    check_outputs();
    model_step();
    cycle(1'b0, 1'b1, 1'b0, 32'd0);
    check_val("first_addr_after_rst", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 300; i++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
